// File: rtl/auto_guess_player_pkg.sv
// Shared types and display constants for the automatic guessing player.
// The segment codes match the game's active-low 7-segment display encoding.
package auto_guess_player_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DECIDE,
        ST_PULSE,
        ST_DONE,
        ST_FAIL
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_ADD1,
        OP_ADD10,
        OP_SUB2
    } opcode_t;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;

endpackage

// File: rtl/auto_guess_player_seg7_decode.sv
// Combinational decode of one active-low 7-segment byte back to a decimal digit.
// Any byte outside the ten digit codes reports valid = 0.
module seg7_decode
    import auto_guess_player_pkg::*;
(
    input  logic [7:0] code,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        case (code)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/auto_guess_player.sv
// Automatic player for the number-guessing game: reads the verdict lights, pulses
// add/sub buttons until green, and decodes the display bytes into the current guess.
module auto_guess_player
    import auto_guess_player_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_STEPS     = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       light_red,
    input  logic       light_gre,
    input  logic       light_yell,
    input  logic [7:0] se1,
    input  logic [7:0] se2,
    output logic       add_1,
    output logic       add_2,
    output logic       add_3,
    output logic       add_5,
    output logic       add_10,
    output logic       sub_1,
    output logic       sub_2,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [6:0] steps,
    output logic [6:0] guess,
    output logic       seg_err
);

    state_t     state, next_state;
    opcode_t    op_sel;
    logic [3:0] settle_cnt;
    logic       fine;
    logic       accept;

    logic       busy_d, done_d, fail_d, add_1_d, add_10_d, sub_2_d;

    logic [3:0] tens_digit, units_digit;
    logic       tens_valid, units_valid;
    logic [6:0] guess_next;

    seg7_decode u_tens  (.code(se1), .digit(tens_digit),  .valid(tens_valid));
    seg7_decode u_units (.code(se2), .digit(units_digit), .valid(units_valid));

    assign guess_next = 7'(tens_digit) * 7'd10 + 7'(units_digit);

    // This policy never uses the remaining buttons.
    assign add_2 = 1'b0;
    assign add_3 = 1'b0;
    assign add_5 = 1'b0;
    assign sub_1 = 1'b0;

    assign accept = start && (state == ST_IDLE || state == ST_DONE || state == ST_FAIL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        op_sel     = OP_NONE;
        case (state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt == 4'd0) next_state = ST_DECIDE;
            end
            ST_DECIDE: begin
                // Green wins over the step budget; anything not one-hot is a broken game.
                case ({light_red, light_gre, light_yell})
                    3'b010: next_state = ST_DONE;
                    3'b100: begin
                        if (steps == 7'(MAX_STEPS)) begin
                            next_state = ST_FAIL;
                        end else begin
                            next_state = ST_PULSE;
                            op_sel     = OP_SUB2;
                        end
                    end
                    3'b001: begin
                        if (steps == 7'(MAX_STEPS)) begin
                            next_state = ST_FAIL;
                        end else begin
                            next_state = ST_PULSE;
                            op_sel     = fine ? OP_ADD1 : OP_ADD10;
                        end
                    end
                    default: next_state = ST_FAIL;
                endcase
            end
            ST_PULSE: next_state = ST_SETTLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs are computed for the upcoming state and then registered.
    always_comb begin
        busy_d   = (next_state == ST_SETTLE) || (next_state == ST_DECIDE) ||
                   (next_state == ST_PULSE);
        done_d   = (next_state == ST_DONE);
        fail_d   = (next_state == ST_FAIL);
        add_1_d  = (next_state == ST_PULSE) && (op_sel == OP_ADD1);
        add_10_d = (next_state == ST_PULSE) && (op_sel == OP_ADD10);
        sub_2_d  = (next_state == ST_PULSE) && (op_sel == OP_SUB2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            add_1      <= 1'b0;
            add_10     <= 1'b0;
            sub_2      <= 1'b0;
            steps      <= 7'd0;
            fine       <= 1'b0;
            settle_cnt <= 4'd0;
            guess      <= 7'd0;
            seg_err    <= 1'b0;
        end else begin
            busy   <= busy_d;
            done   <= done_d;
            fail   <= fail_d;
            add_1  <= add_1_d;
            add_10 <= add_10_d;
            sub_2  <= sub_2_d;

            if (accept) begin
                steps <= 7'd0;
            end else if (state == ST_PULSE && steps != 7'(MAX_STEPS)) begin
                steps <= steps + 7'd1;
            end

            if (accept) begin
                fine <= 1'b0;
            end else if (state == ST_DECIDE && next_state == ST_PULSE && op_sel == OP_SUB2) begin
                fine <= 1'b1;
            end

            if (next_state == ST_SETTLE && state != ST_SETTLE) begin
                settle_cnt <= 4'(SETTLE_CYCLES - 1);
            end else if (state == ST_SETTLE && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end

            if (tens_valid && units_valid) begin
                guess <= guess_next;
            end
            seg_err <= accept ? 1'b0 : (seg_err | ~(tens_valid & units_valid));
        end
    end

endmodule

// File: tb/tb_auto_guess_player.sv
// Directed bench: a behavioural game model answers the player's button pulses,
// and a scoreboard compares every pulse and end state against hand-derived values.
module tb_auto_guess_player;

    localparam logic [6:0] B_ADD1  = 7'b1000000;
    localparam logic [6:0] B_ADD10 = 7'b0000100;
    localparam logic [6:0] B_SUB2  = 7'b0000001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start_b = 1'b0;
    logic       light_red = 1'b0, light_gre = 1'b0, light_yell = 1'b0;
    logic [7:0] se1_m = 8'hC0, se2_m = 8'hC0, se1;

    logic [6:0] btn_a, btn_b, btn;
    logic       busy_a, done_a, fail_a, seg_err_a;
    logic       busy_b, done_b, fail_b, seg_err_b;
    logic [6:0] steps_a, guess_a, steps_b, guess_b;

    int  count = 0;
    int  secret = 0;
    bit  lights_en = 1'b1;
    bit  game_rst = 1'b0;
    bit  seg_bad = 1'b0;
    bit  sel = 1'b0;

    int  n_cmp = 0;
    int  n_err = 0;
    logic [6:0] exp_q[$];

    assign se1 = seg_bad ? 8'hFF : se1_m;
    assign btn = sel ? btn_b : btn_a;

    auto_guess_player dut_a (
        .clk(clk), .rst(rst), .start(start),
        .light_red(light_red), .light_gre(light_gre), .light_yell(light_yell),
        .se1(se1), .se2(se2_m),
        .add_1(btn_a[6]), .add_2(btn_a[5]), .add_3(btn_a[4]), .add_5(btn_a[3]),
        .add_10(btn_a[2]), .sub_1(btn_a[1]), .sub_2(btn_a[0]),
        .busy(busy_a), .done(done_a), .fail(fail_a),
        .steps(steps_a), .guess(guess_a), .seg_err(seg_err_a)
    );

    auto_guess_player #(.MAX_STEPS(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .light_red(light_red), .light_gre(light_gre), .light_yell(light_yell),
        .se1(se1), .se2(se2_m),
        .add_1(btn_b[6]), .add_2(btn_b[5]), .add_3(btn_b[4]), .add_5(btn_b[3]),
        .add_10(btn_b[2]), .sub_1(btn_b[1]), .sub_2(btn_b[0]),
        .busy(busy_b), .done(done_b), .fail(fail_b),
        .steps(steps_b), .guess(guess_b), .seg_err(seg_err_b)
    );

    function automatic logic [7:0] seg_code(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Game model: count follows the pulse one edge later, lights and display one edge after that.
    always @(posedge clk) begin
        if (game_rst) begin
            count <= 0;
        end else begin
            case (btn)
                B_ADD1:  count <= count + 1;
                B_ADD10: count <= count + 10;
                B_SUB2:  count <= (count >= 2) ? count - 2 : 0;
                default: ;
            endcase
        end
        light_red  <= lights_en && (count > secret);
        light_gre  <= lights_en && (count == secret);
        light_yell <= lights_en && (count < secret);
        if (count < 100) se1_m <= seg_code(count / 10);
        se2_m <= seg_code(count % 10);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (btn != 7'd0) begin
            if (exp_q.size() == 0) check("pulse_extra", 32'(btn), 32'd0);
            else check("pulse", 32'(btn), 32'(exp_q.pop_front()));
        end
    end

    task automatic setup_game(input int s, input bit en);
        @(negedge clk);
        secret    = s;
        lights_en = en;
        game_rst  = 1'b1;
        @(negedge clk);
        game_rst  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_exp(input logic [6:0] b, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(b);
    endtask

    task automatic pulse_start(input bit use_b);
        @(negedge clk);
        if (use_b) start_b = 1'b1; else start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_end(input bit use_b, input int budget);
        int n = 0;
        while (!(use_b ? (done_b | fail_b) : (done_a | fail_a)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("end_timeout", 32'(n < budget), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outs", 32'({btn_a, busy_a, done_a, fail_a, steps_a, guess_a, seg_err_a}), 32'd0);
        rst = 1'b0;

        // Secret 37: four tens overshoot to 40, two sub_2 land on 36, add_1 hits 37.
        setup_game(37, 1'b1);
        push_exp(B_ADD10, 4); push_exp(B_SUB2, 2); push_exp(B_ADD1, 1);
        pulse_start(1'b0);
        check("busy_after_start", 32'(busy_a), 32'd1);
        wait_end(1'b0, 200);
        check("s37_done", 32'(done_a), 32'd1);
        check("s37_fail", 32'(fail_a), 32'd0);
        check("s37_steps", 32'(steps_a), 32'd7);
        check("s37_guess", 32'(guess_a), 32'd37);
        check("s37_left", 32'(exp_q.size()), 32'd0);

        // Secret 0: green already lit, DONE exactly SETTLE_CYCLES+1 edges after start.
        setup_game(0, 1'b1);
        pulse_start(1'b0);
        repeat (2) @(negedge clk);
        check("s0_not_yet", 32'(done_a), 32'd0);
        @(negedge clk);
        check("s0_done", 32'(done_a), 32'd1);
        check("s0_steps", 32'(steps_a), 32'd0);
        check("s0_guess", 32'(guess_a), 32'd0);

        // Secret 99: ten tens reach 100 (red), then sub_2, add_1; a start mid-game is ignored.
        setup_game(99, 1'b1);
        push_exp(B_ADD10, 10); push_exp(B_SUB2, 1); push_exp(B_ADD1, 1);
        pulse_start(1'b0);
        repeat (9) @(negedge clk);
        pulse_start(1'b0);
        wait_end(1'b0, 200);
        check("s99_done", 32'(done_a), 32'd1);
        check("s99_steps", 32'(steps_a), 32'd12);
        check("s99_guess", 32'(guess_a), 32'd99);
        check("s99_left", 32'(exp_q.size()), 32'd0);

        // Secret 40 with a budget of 3: still yellow at 30 -> FAIL.
        sel = 1'b1;
        setup_game(40, 1'b1);
        push_exp(B_ADD10, 3);
        pulse_start(1'b1);
        wait_end(1'b1, 100);
        check("budget_fail", 32'(fail_b), 32'd1);
        check("budget_done", 32'(done_b), 32'd0);
        check("budget_steps", 32'(steps_b), 32'd3);
        check("budget_left", 32'(exp_q.size()), 32'd0);
        sel = 1'b0;

        // No lights at all: FAIL on the first DECIDE.
        setup_game(5, 1'b0);
        pulse_start(1'b0);
        repeat (2) @(negedge clk);
        check("dark_not_yet", 32'(fail_a), 32'd0);
        @(negedge clk);
        check("dark_fail", 32'(fail_a), 32'd1);
        check("dark_steps", 32'(steps_a), 32'd0);
        check("dark_busy", 32'(busy_a), 32'd0);

        // Corrupt display mid-game, then reset during the following pulse.
        setup_game(37, 1'b1);
        push_exp(B_ADD10, 3);
        pulse_start(1'b0);
        begin
            int n = 0;
            while (steps_a != 7'd2 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("steps2_timeout", 32'(n < 100), 32'd1);
        end
        repeat (2) @(negedge clk);
        check("guess_before_err", 32'(guess_a), 32'd20);
        seg_bad = 1'b1;
        @(negedge clk);
        check("seg_err_set", 32'(seg_err_a), 32'd1);
        check("guess_held", 32'(guess_a), 32'd20);
        rst = 1'b1;
        seg_bad = 1'b0;
        @(negedge clk);
        check("rst_outs", 32'({btn_a, busy_a, done_a, fail_a, steps_a, guess_a, seg_err_a}), 32'd0);
        check("rst_left", 32'(exp_q.size()), 32'd0);
        rst = 1'b0;

        setup_game(37, 1'b1);
        push_exp(B_ADD10, 4); push_exp(B_SUB2, 2); push_exp(B_ADD1, 1);
        pulse_start(1'b0);
        wait_end(1'b0, 200);
        check("replay_done", 32'(done_a), 32'd1);
        check("replay_steps", 32'(steps_a), 32'd7);
        check("replay_guess", 32'(guess_a), 32'd37);
        check("replay_seg_err", 32'(seg_err_a), 32'd0);
        check("replay_left", 32'(exp_q.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/auto_guess_player.md
# auto_guess_player

Automatic player for the number-guessing game: the responding end of the game's button/light interface. Once the setter has entered matchmode, it reads the three verdict lights, issues one-cycle guess pulses on the add/sub buttons until the green light is reached, and decodes the two 7-segment display bytes back into the current guess value for reporting. It sits beside the game block, driving that block's matching-phase buttons and consuming its lights and display outputs.

## Interface
- SETTLE_CYCLES, 2: idle cycles after each pulse (or after start) before the lights are sampled; legal range 1–15.
- MAX_STEPS, 63: pulse budget; reaching it without green ends in FAIL; legal range 1–127.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to begin a game; honoured only in IDLE, DONE or FAIL.
- light_red, light_gre, light_yell  in  1 each  verdict lights: guess too high, equal, too low.
- se1, se2  in  8 each  active-low 7-segment codes for the tens and units digits.
- add_1, add_2, add_3, add_5, add_10, sub_1, sub_2  out  1 each  button pulses; at most one is high in any cycle.
- busy  out  1  high in SETTLE, DECIDE and PULSE.
- done  out  1  high in DONE.
- fail  out  1  high in FAIL.
- steps  out  7  count of pulses issued in the current game.
- guess  out  7  decoded display value, 0–99.
- seg_err  out  1  sticky flag: an illegal segment code was seen.

## Operation
- The 7-segment codes for digits 0–9 are C0, F9, A4, B0, 99, 92, 82, F8, 80 and 90.
- Each cycle, guess is registered as tens×10 + units from se1/se2.
- If either byte is not a legal code:
  - guess holds its previous value;
  - seg_err is set.
- seg_err is cleared by rst or by an accepted start.
- FSM states are IDLE, SETTLE, DECIDE, PULSE, DONE and FAIL.
- IDLE, DONE or FAIL + start → SETTLE. This clears steps, done, fail, seg_err and fine, and loads the settle counter.
- SETTLE lasts exactly SETTLE_CYCLES cycles, then → DECIDE.
- DECIDE samples the lights once:
  - The lights must be exactly one-hot. Zero lights or more than one light → FAIL.
  - Green → DONE. Green is checked before the step budget.
  - Otherwise, if steps == MAX_STEPS → FAIL.
  - Otherwise → PULSE, with the opcode chosen by the policy below.
- Policy:
  - The fine flag is clear at start.
  - Yellow with fine clear → add_10.
  - Red → set fine, then sub_2.
  - Yellow with fine set → add_1.
- PULSE:
  - Exactly the chosen button is high for this single cycle.
  - steps increments by 1.
  - Next state → SETTLE.
- add_2, add_3, add_5 and sub_1 are never asserted by this policy. They are tied to 0 but kept in the port list for interface completeness.
- start is ignored while busy.
- steps saturates at MAX_STEPS.

## Timing
- Reset values: every output is 0, the state is IDLE, and fine is clear.
- All outputs are registered; there is no combinational path from input to output.
- start at edge e:
  - SETTLE occupies the cycles after e;
  - the first DECIDE is SETTLE_CYCLES cycles later.
- Per-step latency is 1 (PULSE) + SETTLE_CYCLES + 1 (DECIDE) cycles, which is 4 at the default.
- The game block registers the count one edge after the pulse and the lights one edge later. SETTLE_CYCLES ≥ 2 is therefore required for a correct verdict; values below 2 are legal but unsupported.
- guess lags se1/se2 by 1 cycle.
- rst mid-game:
  - abandons the game immediately;
  - no button is high in the following cycle.
- DONE and FAIL hold until the next start or rst. No pulses are issued in either state.

## Structure
- Shared package contains:
  - the FSM state enum;
  - the opcode enum NONE/ADD1/ADD10/SUB2;
  - the ten 7-segment code constants, identical to those the game's display uses.
- One sub-module, seg7_decode: a combinational 8-bit code → 4-bit digit plus valid. It is instantiated twice (tens and units); registering is done in the parent.

## Test plan
- Secret 37 (count 0, yellow):
  - Required pulses: add_10 ×4, then sub_2, sub_2, add_1.
  - Required end state: done=1, steps=7, guess=37, fail=0.
- Secret 0, green already lit at start:
  - First DECIDE → DONE.
  - steps=0; no button is ever pulsed.
- Secret 99:
  - Required pulses: add_10 ×10 (count 100, red), sub_2, add_1.
  - Required end state: done, steps=12.
  - Display byte se1 holds while the count is 100; the bench checks guess=99 at done.
- Secret 40, MAX_STEPS=3: after 3 add_10 pulses DECIDE sees yellow → fail=1, steps=3.
- Lights all 0 (game still in phase 1) at start → fail=1 after SETTLE_CYCLES+1 cycles, steps=0.
- se1=FF injected mid-game:
  - seg_err=1 the next cycle and guess holds.
  - rst two cycles into PULSE/SETTLE → all outputs 0 the next cycle.
  - A new start then plays normally.
